// File: rtl/hack_boot_pkg.sv
// hack_boot_pkg: shared types and constants for the Hack boot loader.
//   WORD_W     - Hack instruction / host word width.
//   HOLD_W     - width of the CPU reset hold down-counter.
//   boot_state_e - loader FSM states; SUM stays in the enum in every build so the
//                  state encoding does not shift with BOOT_CHECKSUM_EN.
//   len_ok()   - legality check for the image length word.
package hack_boot_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [2:0] {
        StLen   = 3'd0,
        StData  = 3'd1,
        StSum   = 3'd2,
        StHold  = 3'd3,
        StRun   = 3'd4,
        StError = 3'd5
    } boot_state_e;

    // An image holds between 1 and 2**addr_w words.
    function automatic logic len_ok(input logic [WORD_W-1:0] n, input int unsigned addr_w);
        logic [31:0] w_n;
        w_n = {{(32 - WORD_W){1'b0}}, n};
        return (n != '0) && (w_n <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/hack_boot_loader_if.sv
// hack_boot_loader_if: host-to-loader word stream (valid/ready).
//   in_valid - host word valid (master -> slave)
//   in_data  - host word       (master -> slave)
//   in_ready - loader accepts  (slave -> master)
// A word transfers on a clock edge where in_valid && in_ready.
interface hack_boot_loader_if;
    import hack_boot_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/boot_checksum_acc.sv
// boot_checksum_acc: 16-bit wrap-around sum of the streamed image words.
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_clear        - zero the sum (start of a new image)
//   i_add          - add i_data to the sum
//   i_data         - data word to add, or checksum word to compare against
//   o_match        - running sum equals i_data
module boot_checksum_acc
    import hack_boot_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_match
);

    logic [WORD_W-1:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_match = (r_sum == i_data);

endmodule

// File: rtl/hack_boot_loader.sv
// hack_boot_loader: streams a program image into the Hack instruction ROM and holds
// the CPU in reset until the image is complete, then releases it.
// Stream: length N, then N data words (then a checksum word with BOOT_CHECKSUM_EN).
// Optional feature macro: BOOT_CHECKSUM_EN (adds SUM state and checksum accumulator).
//   i_clk, i_reset  - clock, synchronous active-high reset
//   io_host         - host word stream (slave side)
//   i_reload        - restart loading; honoured only in RUN
//   o_rom_we/addr/wdata - registered ROM write port
//   o_cpu_reset     - CPU reset, low only in RUN
//   o_done          - image loaded and CPU running
//   o_error         - bad length or checksum; sticky until reset
module hack_boot_loader
    import hack_boot_pkg::*;
#(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hack_boot_loader_if.slave io_host,
    input  logic              i_reload,
    output logic              o_rom_we,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [WORD_W-1:0] o_rom_wdata,
    output logic              o_cpu_reset,
    output logic              o_done,
    output logic              o_error
);

    // One extra bit so a full 2**ADDR_W image length is representable.
    localparam int unsigned LEN_W = ADDR_W + 1;

    boot_state_e       r_state;
    boot_state_e       w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_rom_we;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [WORD_W-1:0] r_rom_wdata;

    logic w_accept;
    logic w_last;

    assign w_accept = io_host.in_valid && io_host.in_ready;
    assign w_last   = ((r_cnt + LEN_W'(1)) == r_len);

`ifdef BOOT_CHECKSUM_EN
    logic w_sum_match;

    boot_checksum_acc u_checksum_acc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (r_state == StLen && w_accept),
        .i_add   (r_state == StData && w_accept),
        .i_data  (io_host.in_data),
        .o_match (w_sum_match)
    );
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StLen;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StLen: begin
                if (w_accept) begin
                    w_state_next = len_ok(io_host.in_data, ADDR_W) ? StData : StError;
                end
            end
            StData: begin
                if (w_accept && w_last) begin
`ifdef BOOT_CHECKSUM_EN
                    w_state_next = StSum;
`else
                    w_state_next = StHold;
`endif
                end
            end
            StSum: begin
`ifdef BOOT_CHECKSUM_EN
                if (w_accept) begin
                    w_state_next = w_sum_match ? StHold : StError;
                end
`else
                w_state_next = StError;
`endif
            end
            StHold: begin
                if (r_hold == '0) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (i_reload) begin
                    w_state_next = StLen;
                end
            end
            StError: w_state_next = StError;
            default: w_state_next = StError;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        io_host.in_ready = 1'b0;
        o_cpu_reset      = 1'b1;
        o_done           = 1'b0;
        o_error          = 1'b0;
        case (r_state)
            StLen, StData, StSum: io_host.in_ready = !i_reset;
            StRun: begin
                o_cpu_reset = 1'b0;
                o_done      = 1'b1;
            end
            StError: o_error = 1'b1;
            default: ;
        endcase
    end

    // Length/counter/hold datapath and registered ROM write port
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_wdata <= '0;
        end else begin
            r_rom_we <= 1'b0;
            if (r_state == StLen && w_accept) begin
                // Truncation only drops zero bits once the length is legal.
                r_len <= LEN_W'(io_host.in_data);
                r_cnt <= '0;
            end
            if (r_state == StData && w_accept) begin
                r_rom_we    <= 1'b1;
                r_rom_addr  <= r_cnt[ADDR_W-1:0];
                r_rom_wdata <= io_host.in_data;
                r_cnt       <= r_cnt + LEN_W'(1);
            end
            if (w_state_next == StHold && r_state != StHold) begin
                r_hold <= HOLD_W'(RESET_HOLD);
            end else if (r_state == StHold && r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    assign o_rom_we    = r_rom_we;
    assign o_rom_addr  = r_rom_addr;
    assign o_rom_wdata = r_rom_wdata;

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb_hack_boot_loader: randomized scoreboard bench for hack_boot_loader.
// The driver pushes the expected ROM writes (address, data, cycle) when each data
// word is accepted; a monitor pops and compares on every rom_we and flags missing or
// stray writes. Release timing, error behaviour and reset values are checked inline.
// Honours BOOT_CHECKSUM_EN the same way as the RTL.
module tb_hack_boot_loader;
    import hack_boot_pkg::*;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned RESET_HOLD = 4;
    localparam int unsigned MAX_LEN    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              reload = 1'b0;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    hack_boot_loader_if host_if ();

    hack_boot_loader #(
        .ADDR_W     (ADDR_W),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .io_host     (host_if),
        .i_reload    (reload),
        .o_rom_we    (rom_we),
        .o_rom_addr  (rom_addr),
        .o_rom_wdata (rom_wdata),
        .o_cpu_reset (cpu_reset),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          due;
    } wr_t;

    wr_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ROM write must match the oldest expected write, in its cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rom_we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rom_write_stray: got addr %0d data 0x%04h, expected no write",
                         rom_addr, rom_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rom_addr !== ADDR_W'(e.addr) || rom_wdata !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rom_write: got addr %0d data 0x%04h cyc %0d, expected addr %0d data 0x%04h cyc %0d",
                             rom_addr, rom_wdata, cyc, e.addr, e.data, e.due);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            e = exp_q.pop_front();
            $display("FAIL rom_write_missing: got no write, expected addr %0d data 0x%04h", e.addr,
                     e.data);
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic idle(input int n, input bit pulse_reload);
        host_if.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            reload = pulse_reload && (i == 0);
            @(posedge clk);
            #1;
            reload = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] w, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        host_if.in_valid = 1'b1;
        host_if.in_data  = w;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = host_if.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        host_if.in_valid = 1'b0;
        host_if.in_data  = 16'($urandom);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected in_ready=1");
        end
    endtask

    // Data word: once accepted it must appear on the ROM port in the next cycle.
    task automatic send_data(input int idx, input logic [15:0] w);
        bit ok;
        send_word(w, ok);
        if (ok) exp_q.push_back('{addr: idx, data: w, due: cyc});
    endtask

    task automatic load_image(input logic [15:0] words[$], input int gap_lo, input int gap_hi,
                              input bit noise, input bit bad_sum);
        bit          ok;
        logic [15:0] sum;
        int          g;
        sum = 16'h0000;
        send_word(16'(words.size()), ok);
        foreach (words[i]) begin
            g = int'($urandom_range(gap_hi, gap_lo));
            if (g > 0) idle(g, noise && ($urandom_range(1, 0) == 1));
            send_data(i, words[i]);
            sum = sum + words[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_word(bad_sum ? sum + 16'h0001 : sum, ok);
`else
        if (bad_sum) idle(0, 1'b0);
`endif
    endtask

    // Call right after the final accept: cpu_reset must drop RESET_HOLD+1 edges later.
    task automatic check_release();
        int c;
        bit saw_ready;
        c = 0;
        saw_ready = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (!cpu_reset) break;
            if (host_if.in_ready) saw_ready = 1'b1;
            c++;
        end
        check("release_delay", c, RESET_HOLD + 1);
        check("hold_in_ready", saw_ready, 0);
        check("run_done", done, 1);
        check("run_error", error, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        check("reload_cpu_reset", cpu_reset, 1);
        check("reload_done", done, 0);
        check("reload_in_ready", host_if.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        reload = 1'b0;
        host_if.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", host_if.in_ready, 0);
        check("rst_rom_we", rom_we, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_wdata", rom_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len_in_ready", host_if.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_error(input string tag);
        @(negedge clk);
        check({tag, "_error"}, error, 1);
        check({tag, "_in_ready"}, host_if.in_ready, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_done"}, done, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] basic[$];
        logic [15:0] words[$];
        bit          ok;

        host_if.in_valid = 1'b0;
        host_if.in_data  = 16'h0000;
        basic = '{16'h1FE0, 16'hEC10, 16'h0010};

        do_reset(2);

        // Basic back-to-back load
        load_image(basic, 0, 0, 1'b0, 1'b0);
        check_release();

        // Reload with a one-word image
        do_reload();
        words = '{16'hAAAA};
        load_image(words, 0, 0, 1'b0, 1'b0);
        check_release();

        // Backpressure: two idle cycles between every word
        do_reload();
        load_image(basic, 2, 2, 1'b0, 1'b0);
        check_release();

        // Random images, random gaps, stray reload pulses that must be ignored
        for (int t = 0; t < 6; t++) begin
            do_reload();
            words.delete();
            for (int i = 0; i < int'($urandom_range(MAX_LEN, 1)); i++) words.push_back(16'($urandom));
            load_image(words, 0, 3, 1'b1, 1'b0);
            check_release();
        end

        // Length one past the maximum, then reload must not leave ERROR
        do_reload();
        send_word(16'(MAX_LEN + 1), ok);
        check_error("len_too_big");
        idle(1, 1'b1);
        check_error("error_sticky");

        // Maximum-length image fills every address
        do_reset(1);
        words.delete();
        for (int i = 0; i < int'(MAX_LEN); i++) words.push_back(16'($urandom));
        load_image(words, 0, 0, 1'b0, 1'b0);
        check_release();

        // Zero length
        do_reset(1);
        send_word(16'h0000, ok);
        check_error("len_zero");

`ifdef BOOT_CHECKSUM_EN
        do_reset(1);
        words = '{16'h1FE0, 16'hEC10};
        load_image(words, 0, 1, 1'b0, 1'b0);
        check_release();
        do_reset(1);
        load_image(words, 0, 0, 1'b0, 1'b1);
        check_error("bad_sum");
`endif

        // Reset after the first of three data words, then a fresh two-word load
        do_reset(1);
        send_word(16'd3, ok);
        send_data(0, 16'h1234);
        do_reset(1);
        words = '{16'h5A5A, 16'hC3C3};
        load_image(words, 0, 0, 1'b0, 1'b0);
        check_release();

        idle(4, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
